// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are captured on an
// accepted start, then compared MSB-first, DIGIT bits per clock. It supports
// unsigned and two's-complement order. The result is reported as one-hot
// eq/gt/lt flags, which are qualified by a one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand width in bits; must be an exact multiple of DIGIT
//   DIGIT  bits examined per COMPARE cycle (1 <= DIGIT <= WIDTH)
//
// Ports:
//   clk          single rising-edge clock
//   rst          synchronous reset, active-high; abandons any operation
//   start        request a comparison; honoured only in IDLE
//   a, b         operands; sampled only on the accepted-start edge
//   signed_mode  1 = two's-complement compare; sampled with the operands
//   busy         high while comparing
//   done         one-cycle pulse; eq/gt/lt are valid from this cycle on
//   eq, gt, lt   comparison result (A == B, A > B, A < B); each holds until
//                the next accepted start or rst
//
// Build option:
//   SEQ_COMPARATOR_EARLY_EXIT_EN  when defined, the comparison stops at the
//   first mismatching digit, so latency depends on the data. When undefined,
//   all WIDTH/DIGIT digits are always examined and latency is constant. The
//   results are the same in both builds.
// -----------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject parameter combinations at elaboration.
  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               decided_q;
  logic               busy_q;
  logic               done_q;
  logic               eq_q;
  logic               gt_q;
  logic               lt_q;

  // Operand copies as they are loaded into the shift registers. In signed
  // mode the sign bit is flipped (offset binary). A plain unsigned digit
  // compare then yields the two's-complement order.
  logic [WIDTH-1:0]   a_cap_d;
  logic [WIDTH-1:0]   b_cap_d;

  // Digit currently at the top of each shift register
  logic [DIGIT-1:0]   dig_a;
  logic [DIGIT-1:0]   dig_b;
  logic               dig_gt;
  logic               first_mismatch;
  logic               last_digit;

  always_comb begin
    a_cap_d            = a;
    b_cap_d            = b;
    a_cap_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
    b_cap_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
  end

  always_comb begin
    dig_a          = a_sh_q[WIDTH-1 -: DIGIT];
    dig_b          = b_sh_q[WIDTH-1 -: DIGIT];
    dig_gt         = (dig_a > dig_b);
    // Only the first differing digit decides. Once decided, later digits are
    // ignored so that constant-time mode gives the same answer.
    first_mismatch = !decided_q && (dig_a != dig_b);
    last_digit     = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= COMPARE;
            busy_q    <= 1'b1;
            a_sh_q    <= a_cap_d;
            b_sh_q    <= b_cap_d;
            cnt_q     <= CNT_LOAD;
            decided_q <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
          end
        end

        COMPARE: begin
          a_sh_q <= a_sh_q << DIGIT;
          b_sh_q <= b_sh_q << DIGIT;
          cnt_q  <= cnt_q - CNT_ONE;

          if (first_mismatch) begin
            decided_q <= 1'b1;
            gt_q      <= dig_gt;
            lt_q      <= !dig_gt;
          end

`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
          // Leave on the first mismatch. Otherwise leave after the last
          // digit, which can only be reached if every digit matched.
          if (first_mismatch) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (last_digit) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            eq_q    <= 1'b1;
          end
`else
          // Always walk every digit. A result decided earlier is retained.
          if (last_digit) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!decided_q && !first_mismatch) begin
              eq_q <= 1'b1;
            end
          end
`endif
        end

        DONE: begin
          // Pulse lasts exactly one cycle; a start seen here is ignored
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//
// Self-checking bench for seq_magnitude_comparator. It drives two instances
// from shared operand inputs: WIDTH=8 with DIGIT=1, and WIDTH=8 with DIGIT=4.
// The expected eq/gt/lt flags come from integer arithmetic on the operands.
// The expected latency comes from the position of the highest differing bit.
// -----------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

  logic       clk;
  logic       rst;
  logic       start_s;
  logic       sel4;          // 0 = DIGIT 1 instance, 1 = DIGIT 4 instance
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       sm_s;

  logic busy1, done1, eq1, gt1, lt1;
  logic busy4, done4, eq4, gt4, lt4;
  logic busy_o, done_o, eq_o, gt_o, lt_o;

  int checks   = 0;
  int failures = 0;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s & ~sel4),
    .a           (a_s),
    .b           (b_s),
    .signed_mode (sm_s),
    .busy        (busy1),
    .done        (done1),
    .eq          (eq1),
    .gt          (gt1),
    .lt          (lt1)
  );

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s & sel4),
    .a           (a_s),
    .b           (b_s),
    .signed_mode (sm_s),
    .busy        (busy4),
    .done        (done4),
    .eq          (eq4),
    .gt          (gt4),
    .lt          (lt4)
  );

  always_comb begin
    busy_o = sel4 ? busy4 : busy1;
    done_o = sel4 ? done4 : done1;
    eq_o   = sel4 ? eq4   : eq1;
    gt_o   = sel4 ? gt4   : gt1;
    lt_o   = sel4 ? lt4   : lt1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected cycles from the start edge to the edge that raises done
  function automatic int exp_latency(input int digit, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] diff;
    int         hb;
    diff = x ^ y;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    if (diff == 8'h00) return 8 / digit;
    hb = 7;
    while (!diff[hb]) hb--;
    return ((7 - hb) / digit) + 1;
`else
    hb = int'(diff != 8'h00);
    return (8 / digit) + (hb * 0);
`endif
  endfunction

  // One comparison, started in the current cycle (call #1 after an edge).
  // It leaves the bench #1 after the edge that follows the done pulse.
  task automatic do_cmp(input logic use4, input logic [7:0] x, input logic [7:0] y,
                        input logic sm, input logic poke);
    int  ia, ib, lat, exp_lat, digit;
    logic e_eq, e_gt, e_lt, got;
    digit   = use4 ? 4 : 1;
    ia      = sm ? int'($signed(x)) : int'({24'd0, x});
    ib      = sm ? int'($signed(y)) : int'({24'd0, y});
    e_eq    = (ia == ib);
    e_gt    = (ia > ib);
    e_lt    = (ia < ib);
    exp_lat = exp_latency(digit, x, y);

    sel4 = use4; a_s = x; b_s = y; sm_s = sm; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    // Scramble the inputs; the captured operands must be the only ones used
    a_s = 8'($urandom); b_s = 8'($urandom); sm_s = 1'($urandom);
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    check("flags_clear_after_start", {29'd0, eq_o, gt_o, lt_o}, 32'd0);

    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done_o) begin
        got = 1'b1;
      end else begin
        check("busy_during_compare", {31'd0, busy_o}, 32'd1);
        if (poke && lat == 1) begin
          start_s = 1'b1; a_s = ~x; b_s = ~y;
        end else begin
          start_s = 1'b0;
        end
      end
    end
    start_s = 1'b0;
    if (!got) check("done_seen", 32'd0, 32'd1);
    check("latency", lat, exp_lat);
    check("busy_at_done", {31'd0, busy_o}, 32'd0);
    check("eq", {31'd0, eq_o}, {31'd0, e_eq});
    check("gt", {31'd0, gt_o}, {31'd0, e_gt});
    check("lt", {31'd0, lt_o}, {31'd0, e_lt});

    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
    check("idle_after_done", {31'd0, busy_o}, 32'd0);
    check("flags_hold", {29'd0, eq_o, gt_o, lt_o}, {29'd0, e_eq, e_gt, e_lt});
    $display("txn digit=%0d a=%02h b=%02h signed=%0d lat=%0d eq=%0d gt=%0d lt=%0d",
             digit, x, y, sm, lat, eq_o, gt_o, lt_o);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start_s = 1'b0; sel4 = 1'b0; a_s = '0; b_s = '0; sm_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut1", {27'd0, busy1, done1, eq1, gt1, lt1}, 32'd0);
    check("reset_dut4", {27'd0, busy4, done4, eq4, gt4, lt4}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases; consecutive calls also exercise back-to-back starts
    do_cmp(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
    do_cmp(1'b0, 8'h80, 8'h7F, 1'b0, 1'b0);
    do_cmp(1'b0, 8'h80, 8'h7F, 1'b1, 1'b0);
    do_cmp(1'b0, 8'h12, 8'h13, 1'b0, 1'b0);
    do_cmp(1'b1, 8'h3C, 8'h3D, 1'b0, 1'b0);
    do_cmp(1'b1, 8'hF0, 8'h3C, 1'b1, 1'b0);
    // A start pulsed while busy with other operands must be ignored
    do_cmp(1'b0, 8'h12, 8'h13, 1'b0, 1'b1);
    do_cmp(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of COMPARE
    sel4 = 1'b0; a_s = 8'hA5; b_s = 8'hA5; sm_s = 1'b0; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_rst", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_outputs", {27'd0, busy1, done1, eq1, gt1, lt1}, 32'd0);
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done1) dones++;
    end
    check("rst_mid_no_done", dones, 0);
    do_cmp(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);

    // Randomised comparisons, with a bias toward equal and near-equal operands
    for (int i = 0; i < 150; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (8'h01 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      do_cmp(1'($urandom), x, y, 1'($urandom), 1'($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
